// File: rtl/reset_sequencer.sv
// Reset sequencer: merges reset sources, holds all domains in reset for a minimum time,
// waits for stable PLL lock, then releases domains in ascending order. Keeps a sticky reset cause.
module reset_sequencer #(
    parameter int unsigned NDOMAINS     = 4,
    parameter int unsigned HOLD_CYCLES  = 256,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned STAGE_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_button,
    input  logic                req_debug,
    input  logic                pll_locked,
    input  logic                cause_clear,
    output logic [NDOMAINS-1:0] domain_reset,
    output logic                busy,
    output logic                done,
    output logic [3:0]          cause
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned STB_W   = $clog2(LOCK_STABLE + 1);
    localparam int unsigned IDX_W   = (NDOMAINS > 1) ? $clog2(NDOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST   = STB_W'(LOCK_STABLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDOMAINS - 1);

    typedef enum logic [1:0] {
        S_ASSERT,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NDOMAINS-1:0] rst_d;
    logic [3:0]          cause_set;
    logic                request;
    logic                lock_abort;

    assign request    = req_button | req_debug;
    assign lock_abort = !pll_locked && (state_q == S_RELEASE || state_q == S_RUN);
    assign cause_set  = {lock_abort, req_debug, req_button, 1'b0};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        idx_d    = idx_q;
        rst_d    = domain_reset;

        case (state_q)
            S_ASSERT: begin
                rst_d    = '1;
                stable_d = '0;
                idx_d    = '0;
                if (request) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (!pll_locked) begin
                    stable_d = '0;
                end else if (stable_q == STB_LAST) begin
                    stable_d = '0;
                    cnt_d    = '0;
                    rst_d[0] = 1'b0;
                    if (NDOMAINS == 1) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == STAGE_LAST) begin
                    cnt_d        = '0;
                    rst_d[idx_q] = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                rst_d = '0;
            end
            default: begin
                state_d = S_ASSERT;
                rst_d   = '1;
            end
        endcase

        // Abort overrides any release scheduled on the same edge.
        if (state_q != S_ASSERT && (request || lock_abort)) begin
            state_d  = S_ASSERT;
            rst_d    = '1;
            cnt_d    = '0;
            stable_d = '0;
            idx_d    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_ASSERT;
            cnt_q        <= '0;
            stable_q     <= '0;
            idx_q        <= '0;
            domain_reset <= '1;
            busy         <= 1'b1;
            done         <= 1'b0;
            cause        <= 4'b0001;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            idx_q        <= idx_d;
            domain_reset <= rst_d;
            busy         <= (state_d != S_RUN);
            done         <= (state_d == S_RUN);
            cause        <= (cause & {4{~cause_clear}}) | cause_set;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NDOMAINS=4, HOLD=4, LOCK_STABLE=3, STAGE=2.
module tb_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_button;
    logic       req_debug;
    logic       pll_locked;
    logic       cause_clear;
    logic [3:0] domain_reset;
    logic       busy;
    logic       done;
    logic [3:0] cause;

    int unsigned errors = 0;
    int unsigned checks = 0;

    reset_sequencer #(
        .NDOMAINS    (4),
        .HOLD_CYCLES (4),
        .LOCK_STABLE (3),
        .STAGE_CYCLES(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_button  (req_button),
        .req_debug   (req_debug),
        .pll_locked  (pll_locked),
        .cause_clear (cause_clear),
        .domain_reset(domain_reset),
        .busy        (busy),
        .done        (done),
        .cause       (cause)
    );

    always #5 clock = ~clock;

    // Expected resets 'rel' edges after the last edge that saw a reset/request/abort,
    // with lock held: hold 4 + stable 3 = 7, then one domain every 2 edges.
    function automatic logic [3:0] exp_dr(input int unsigned rel);
        if (rel < 7)       return 4'b1111;
        else if (rel < 9)  return 4'b1110;
        else if (rel < 11) return 4'b1100;
        else if (rel < 13) return 4'b1000;
        else               return 4'b0000;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic lock);
        reset       = 1'b1;
        req_button  = 1'b0;
        req_debug   = 1'b0;
        cause_clear = 1'b0;
        pll_locked  = lock;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if (domain_reset !== 4'b1111) begin
            errors++;
            $display("FAIL reset_dr: got %b expected 1111", domain_reset);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_done: got busy=%b done=%b expected 1/0", busy, done);
        end
        checks++;
        if (cause !== 4'b0001) begin
            errors++;
            $display("FAIL reset_cause: got %b expected 0001", cause);
        end
    endtask

    task automatic test_power_on();
        do_reset(1'b1);
        for (int e = 1; e <= 15; e++) begin
            step();
            checks++;
            if (domain_reset !== exp_dr(e) || done !== (e >= 13) || busy !== (e < 13)) begin
                errors++;
                $display("FAIL power_on e%0d: got dr=%b done=%b busy=%b expected dr=%b done=%b",
                         e, domain_reset, done, busy, exp_dr(e), (e >= 13));
            end
        end
        checks++;
        if (cause !== 4'b0001) begin
            errors++;
            $display("FAIL power_on_cause: got %b expected 0001", cause);
        end
    endtask

    task automatic test_late_lock();
        logic [3:0] exp;
        do_reset(1'b0);
        for (int e = 1; e <= 16; e++) begin
            pll_locked = (e >= 10 && e != 11);
            step();
            exp = (e < 14) ? 4'b1111 : (e < 16) ? 4'b1110 : 4'b1100;
            checks++;
            if (domain_reset !== exp) begin
                errors++;
                $display("FAIL late_lock e%0d: got %b expected %b", e, domain_reset, exp);
            end
        end
        checks++;
        if (cause !== 4'b0001) begin
            errors++;
            $display("FAIL late_lock_cause: got %b expected 0001", cause);
        end
    endtask

    task automatic test_button_release();
        do_reset(1'b1);
        repeat (9) step();
        req_button = 1'b1;
        step();
        req_button = 1'b0;
        checks++;
        if (domain_reset !== 4'b1111 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL button_abort: got dr=%b busy=%b done=%b expected 1111/1/0",
                     domain_reset, busy, done);
        end
        checks++;
        if (cause !== 4'b0011) begin
            errors++;
            $display("FAIL button_cause: got %b expected 0011", cause);
        end
        for (int r = 1; r <= 9; r++) begin
            step();
            checks++;
            if (domain_reset !== exp_dr(r)) begin
                errors++;
                $display("FAIL button_replay r%0d: got %b expected %b", r, domain_reset, exp_dr(r));
            end
        end
    endtask

    task automatic test_abort_wins();
        do_reset(1'b1);
        repeat (10) step();
        req_debug = 1'b1;
        step();
        req_debug = 1'b0;
        checks++;
        if (domain_reset !== 4'b1111 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_wins: got dr=%b done=%b expected 1111/0", domain_reset, done);
        end
        checks++;
        if (cause !== 4'b0101) begin
            errors++;
            $display("FAIL abort_wins_cause: got %b expected 0101", cause);
        end
    endtask

    task automatic test_lock_loss_run();
        do_reset(1'b1);
        repeat (13) step();
        checks++;
        if (done !== 1'b1 || domain_reset !== 4'b0000) begin
            errors++;
            $display("FAIL run_reached: got done=%b dr=%b expected 1/0000", done, domain_reset);
        end
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        checks++;
        if (domain_reset !== 4'b1111 || busy !== 1'b1 || done !== 1'b0 || cause !== 4'b1001) begin
            errors++;
            $display("FAIL lock_loss: got dr=%b busy=%b done=%b cause=%b expected 1111/1/0/1001",
                     domain_reset, busy, done, cause);
        end
        for (int r = 1; r <= 14; r++) begin
            step();
            checks++;
            if (domain_reset !== exp_dr(r) || done !== (r >= 13)) begin
                errors++;
                $display("FAIL lock_replay r%0d: got dr=%b done=%b expected dr=%b done=%b",
                         r, domain_reset, done, exp_dr(r), (r >= 13));
            end
        end
    endtask

    task automatic test_simul_clear();
        do_reset(1'b1);
        repeat (13) step();
        req_button  = 1'b1;
        req_debug   = 1'b1;
        cause_clear = 1'b1;
        step();
        req_button  = 1'b0;
        req_debug   = 1'b0;
        cause_clear = 1'b0;
        checks++;
        if (cause !== 4'b0110 || domain_reset !== 4'b1111) begin
            errors++;
            $display("FAIL simul_cause: got cause=%b dr=%b expected 0110/1111", cause, domain_reset);
        end
        step();
        checks++;
        if (cause !== 4'b0110) begin
            errors++;
            $display("FAIL sticky_cause: got %b expected 0110", cause);
        end
        cause_clear = 1'b1;
        step();
        cause_clear = 1'b0;
        checks++;
        if (cause !== 4'b0000) begin
            errors++;
            $display("FAIL lone_clear: got %b expected 0000", cause);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (cause !== 4'b0001 || domain_reset !== 4'b1111) begin
            errors++;
            $display("FAIL midop_reset: got cause=%b dr=%b expected 0001/1111", cause, domain_reset);
        end
    endtask

    task automatic test_held_request();
        do_reset(1'b1);
        req_debug = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if (domain_reset !== 4'b1111 || busy !== 1'b1) begin
                errors++;
                $display("FAIL held_req e%0d: got dr=%b busy=%b expected 1111/1", e, domain_reset, busy);
            end
        end
        req_debug = 1'b0;
        checks++;
        if (cause !== 4'b0101) begin
            errors++;
            $display("FAIL held_cause: got %b expected 0101", cause);
        end
        for (int r = 1; r <= 8; r++) begin
            step();
            checks++;
            if (domain_reset !== exp_dr(r)) begin
                errors++;
                $display("FAIL held_release r%0d: got %b expected %b", r, domain_reset, exp_dr(r));
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_button  = 1'b0;
        req_debug   = 1'b0;
        pll_locked  = 1'b0;
        cause_clear = 1'b0;
        test_reset();
        test_power_on();
        test_late_lock();
        test_button_release();
        test_abort_wins();
        test_lock_loss_run();
        test_simul_clear();
        test_held_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
